// File: rtl/cbfp_block_norm_pkg.sv
// Shared types, widths and the redundant-sign counter for the CBFP block normaliser.
// Widths here are the datapath defaults; the top's parameters default to them.
package cbfp_pkg;

    localparam int CBFP_DIN_W   = 23;
    localparam int CBFP_EXP_W   = $clog2(CBFP_DIN_W);
    localparam int CBFP_BLK_CYC = 4;
    localparam int BEAT_W       = $clog2(CBFP_BLK_CYC);

    typedef enum logic {IDLE, DRAIN} rd_state_e;

    // Leading bits equal to the MSB, minus one: 0/-1 -> DIN_W-1, most-negative -> 0.
    function automatic logic [CBFP_EXP_W-1:0] sign_cnt(input logic signed [CBFP_DIN_W-1:0] x);
        logic [CBFP_EXP_W-1:0] cnt;
        logic                  run;
        cnt = '0;
        run = 1'b1;
        for (int i = CBFP_DIN_W - 2; i >= 0; i--) begin
            if (run && (x[i] == x[CBFP_DIN_W-1])) cnt = cnt + CBFP_EXP_W'(1);
            else run = 1'b0;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/cbfp_block_norm_min_cnt.sv
// Combinational minimum redundant-sign count over all real and imaginary lanes of one beat.
module cbfp_min_cnt
    import cbfp_pkg::*;
#(
    parameter int LANES = 16,
    parameter int DIN_W = CBFP_DIN_W,
    parameter int EXP_W = $clog2(DIN_W)
) (
    input  logic [LANES-1:0][DIN_W-1:0] din_re,
    input  logic [LANES-1:0][DIN_W-1:0] din_im,
    output logic [EXP_W-1:0]            beat_min
);

    logic [2*LANES-1:0][EXP_W-1:0] cnt;

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            cnt[l]         = sign_cnt($signed(din_re[l]));
            cnt[LANES + l] = sign_cnt($signed(din_im[l]));
        end
    end

    always_comb begin
        beat_min = EXP_W'(DIN_W - 1);
        for (int k = 0; k < 2 * LANES; k++) begin
            if (cnt[k] < beat_min) beat_min = cnt[k];
        end
    end

endmodule

// File: rtl/cbfp_block_norm.sv
// Block-floating-point normaliser: ping-pong buffers BLK_CYC beats, then replays them
// left-shifted by the block's minimum redundant-sign count. BLK_CYC must be a power of two.
module cbfp_block_norm
    import cbfp_pkg::*;
#(
    parameter int LANES   = 16,
    parameter int BLK_CYC = CBFP_BLK_CYC,
    parameter int DIN_W   = CBFP_DIN_W,
    parameter int DOUT_W  = 11,
    parameter int EXP_W   = $clog2(DIN_W)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic                         cbfp_en,
    input  logic [LANES-1:0][DIN_W-1:0]  din_re,
    input  logic [LANES-1:0][DIN_W-1:0]  din_im,
    output logic                         valid_out,
    output logic [LANES-1:0][DOUT_W-1:0] dout_re,
    output logic [LANES-1:0][DOUT_W-1:0] dout_im,
    output logic [EXP_W-1:0]             dout_exp,
    output logic                         blk_last,
    output rd_state_e                    dbg_state
);

    // valid_in: one beat accepted per cycle it is high, no ready (block fill time covers
    // drain time). valid_out: one output beat per cycle it is high; blk_last tags the final beat.

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLK_CYC - 1);

    logic [2*LANES*DIN_W-1:0] mem [2*BLK_CYC];

    logic [BEAT_W-1:0] beat_cnt, rd_row, rd_row_sel;
    logic              wr_bank, rd_bank;
    logic [EXP_W-1:0]  beat_min, run_min, cur_min, blk_min, cur_shift, new_shift, rd_shift;
    logic              en_hold, cur_en, blk_en, blk_ready, blk_done, rd_take;
    rd_state_e         state;

    logic [2*LANES*DIN_W-1:0]     rd_word;
    logic [LANES-1:0][DIN_W-1:0]  sh_re, sh_im;
    logic [LANES-1:0][DOUT_W-1:0] nxt_re, nxt_im;

    cbfp_min_cnt #(.LANES(LANES), .DIN_W(DIN_W), .EXP_W(EXP_W)) u_min_cnt (
        .din_re   (din_re),
        .din_im   (din_im),
        .beat_min (beat_min)
    );

    // Beat 0 reloads the running minimum and enable instead of folding in the previous block.
    always_comb begin
        cur_min  = (beat_cnt == '0) ? beat_min : ((beat_min < run_min) ? beat_min : run_min);
        cur_en   = (beat_cnt == '0) ? cbfp_en : en_hold;
        blk_done = valid_in && (beat_cnt == LAST_BEAT);
    end

    always_ff @(posedge clk) begin
        if (valid_in) mem[{wr_bank, beat_cnt}] <= {din_im, din_re};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            wr_bank  <= 1'b0;
            run_min  <= '0;
            en_hold  <= 1'b0;
            blk_min  <= '0;
            blk_en   <= 1'b0;
        end else if (valid_in) begin
            run_min <= cur_min;
            en_hold <= cur_en;
            if (beat_cnt == LAST_BEAT) begin
                beat_cnt <= '0;
                wr_bank  <= ~wr_bank;
                blk_min  <= cur_min;
                blk_en   <= cur_en;
            end else begin
                beat_cnt <= beat_cnt + BEAT_W'(1);
            end
        end
    end

    // IDLE emits row 0 in the same cycle it accepts a block, so the first beat is not delayed.
    always_comb begin
        new_shift  = blk_en ? blk_min : '0;
        rd_shift   = (state == IDLE) ? new_shift : cur_shift;
        rd_row_sel = (state == IDLE) ? '0 : rd_row;
        rd_take    = blk_ready && ((state == IDLE) || (rd_row == LAST_BEAT));
        rd_word    = mem[{rd_bank, rd_row_sel}];
        for (int l = 0; l < LANES; l++) begin
            sh_re[l]  = rd_word[l * DIN_W +: DIN_W] << rd_shift;
            sh_im[l]  = rd_word[(LANES + l) * DIN_W +: DIN_W] << rd_shift;
            nxt_re[l] = sh_re[l][DIN_W-1 -: DOUT_W];
            nxt_im[l] = sh_im[l][DIN_W-1 -: DOUT_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd_row    <= '0;
            rd_bank   <= 1'b0;
            cur_shift <= '0;
            blk_ready <= 1'b0;
            valid_out <= 1'b0;
            blk_last  <= 1'b0;
            dout_re   <= '0;
            dout_im   <= '0;
            dout_exp  <= '0;
        end else begin
            if (blk_done) blk_ready <= 1'b1;
            else if (rd_take) blk_ready <= 1'b0;

            case (state)
                IDLE: begin
                    if (blk_ready) begin
                        state     <= DRAIN;
                        rd_row    <= BEAT_W'(1);
                        cur_shift <= new_shift;
                        valid_out <= 1'b1;
                        blk_last  <= 1'b0;
                        dout_re   <= nxt_re;
                        dout_im   <= nxt_im;
                        dout_exp  <= rd_shift;
                    end else begin
                        valid_out <= 1'b0;
                        blk_last  <= 1'b0;
                        dout_re   <= '0;
                        dout_im   <= '0;
                        dout_exp  <= '0;
                    end
                end
                DRAIN: begin
                    valid_out <= 1'b1;
                    blk_last  <= (rd_row == LAST_BEAT);
                    dout_re   <= nxt_re;
                    dout_im   <= nxt_im;
                    dout_exp  <= rd_shift;
                    if (rd_row == LAST_BEAT) begin
                        rd_row  <= '0;
                        rd_bank <= ~rd_bank;
                        if (blk_ready) cur_shift <= new_shift;
                        else state <= IDLE;
                    end else begin
                        rd_row <= rd_row + BEAT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_cbfp_block_norm.sv
// Directed scoreboard bench for cbfp_block_norm: expected beats and their arrival cycles are
// queued at stimulus time and popped by an independent output monitor.
module tb_cbfp_block_norm;
  import cbfp_pkg::*;

  localparam int LANES   = 16;
  localparam int BLK_CYC = 4;
  localparam int DIN_W   = 23;
  localparam int DOUT_W  = 11;
  localparam int EXP_W   = $clog2(DIN_W);
  localparam int W       = 1 + EXP_W + 2 * LANES * DOUT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                         valid_in, cbfp_en;
  logic [LANES-1:0][DIN_W-1:0]  din_re, din_im;
  logic                         valid_out, blk_last;
  logic [LANES-1:0][DOUT_W-1:0] dout_re, dout_im;
  logic [EXP_W-1:0]             dout_exp;
  rd_state_e                    dbg_state;

  cbfp_block_norm #(
    .LANES(LANES), .BLK_CYC(BLK_CYC), .DIN_W(DIN_W), .DOUT_W(DOUT_W), .EXP_W(EXP_W)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .cbfp_en(cbfp_en),
    .din_re(din_re), .din_im(din_im),
    .valid_out(valid_out), .dout_re(dout_re), .dout_im(dout_im),
    .dout_exp(dout_exp), .blk_last(blk_last), .dbg_state(dbg_state)
  );

  // ---------------- stimulus tables ----------------
  int blk_re [BLK_CYC][LANES];
  int blk_im [BLK_CYC][LANES];
  int ex_re  [BLK_CYC][LANES];
  int ex_im  [BLK_CYC][LANES];
  int ex_exp;
  int last_cyc;

  logic [W-1:0] exp_q[$];
  int           cyc_q[$];

  logic quiet    = 1'b1;
  logic end_req  = 1'b0;
  logic end_done = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  // Alternating-sign pattern: samples +/-amp, outputs pos_out / neg_out by sign.
  task automatic fill_mix(input int amp, input int pos_out, input int neg_out);
    for (int b = 0; b < BLK_CYC; b++) begin
      for (int l = 0; l < LANES; l++) begin
        if (((l + b) % 2) == 0) begin
          blk_re[b][l] = amp;  blk_im[b][l] = -amp;
          ex_re[b][l] = pos_out; ex_im[b][l] = neg_out;
        end else begin
          blk_re[b][l] = -amp; blk_im[b][l] = amp;
          ex_re[b][l] = neg_out; ex_im[b][l] = pos_out;
        end
      end
    end
  endtask

  task automatic fill_const(input int re, input int im, input int ore, input int oim);
    for (int b = 0; b < BLK_CYC; b++) begin
      for (int l = 0; l < LANES; l++) begin
        blk_re[b][l] = re;  blk_im[b][l] = im;
        ex_re[b][l]  = ore; ex_im[b][l]  = oim;
      end
    end
  endtask

  function automatic logic [W-1:0] pack_beat(input int j);
    logic [LANES-1:0][DOUT_W-1:0] r, i;
    logic [31:0] tr, ti;
    for (int l = 0; l < LANES; l++) begin
      tr = ex_re[j][l];
      ti = ex_im[j][l];
      r[l] = tr[DOUT_W-1:0];
      i[l] = ti[DOUT_W-1:0];
    end
    return {(j == BLK_CYC - 1), EXP_W'(ex_exp), i, r};
  endfunction

  // ---------------- driver tasks (entered at posedge + 1) ----------------
  task automatic drive_beat(input int b, input logic en);
    logic [31:0] tr, ti;
    valid_in = 1'b1;
    cbfp_en  = en;
    for (int l = 0; l < LANES; l++) begin
      tr = blk_re[b][l];
      ti = blk_im[b][l];
      din_re[l] = tr[DIN_W-1:0];
      din_im[l] = ti[DIN_W-1:0];
    end
    last_cyc = cyc;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    valid_in = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // en_mask bit b is the cbfp_en level driven with beat b.
  task automatic send_block(input logic [BLK_CYC-1:0] en_mask, input logic gapped);
    for (int b = 0; b < BLK_CYC; b++) begin
      drive_beat(b, en_mask[b]);
      if (gapped && b < BLK_CYC - 1) idle_cycles(1);
    end
    for (int j = 0; j < BLK_CYC; j++) begin
      exp_q.push_back(pack_beat(j));
      cyc_q.push_back(last_cyc + 2 + j);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
    idle_cycles(2);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] got, want;
    int           t;
    if (quiet) begin
      checks++;
      if (valid_out !== 1'b0 || blk_last !== 1'b0 || dout_re !== '0 || dout_im !== '0 || dout_exp !== '0) begin
        errors++;
        $display("FAIL quiet_outputs @%0d valid=%b last=%b exp=%0d re=%h required all zero",
                 cyc, valid_out, blk_last, dout_exp, dout_re);
      end
    end
    if (valid_out === 1'b1) begin
      got = {blk_last, dout_exp, dout_im, dout_re};
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat @%0d got=%h", cyc, got);
      end else begin
        want = exp_q.pop_front();
        t    = cyc_q.pop_front();
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL beat_data @%0d got=%h exp=%h", cyc, got, want);
        end
        checks++;
        if (cyc != t) begin
          errors++;
          $display("FAIL beat_time got cycle %0d required cycle %0d", cyc, t);
        end
      end
    end
    if (end_req && !end_done) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL missing_beats %0d expected beats never appeared (required 0)", exp_q.size());
      end
      end_done <= 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; valid_in = 1'b0; cbfp_en = 1'b0; din_re = '0; din_im = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(2);
    quiet = 1'b0;

    // Mixed-sign +/-256: exp 13, outputs +/-512, gapless.
    fill_mix(256, 512, -512); ex_exp = 13;
    send_block('1, 1'b0);
    wait_drain();

    // One full-scale sample among fives: exp 0, only that sample survives truncation.
    fill_const(5, 5, 0, 0);
    blk_re[2][3] = 32'h3FFFFF; ex_re[2][3] = 1023; ex_exp = 0;
    send_block('1, 1'b0);
    wait_drain();

    // All-zero block then +/-256 back to back: minimum must reload.
    fill_const(0, 0, 0, 0); ex_exp = 22;
    send_block('1, 1'b0);
    fill_mix(256, 512, -512); ex_exp = 13;
    send_block('1, 1'b0);
    wait_drain();

    // Gapped block A (1000/-1000, exp 12) followed immediately by gapless B (100/-2, exp 15).
    fill_const(1000, -1000, 1000, -1000); ex_exp = 12;
    send_block('1, 1'b1);
    fill_const(100, -2, 800, -16); ex_exp = 15;
    send_block('1, 1'b0);
    wait_drain();

    // cbfp_en = 0: plain truncation.
    fill_mix(256, 0, -1); ex_exp = 0;
    send_block(4'b0000, 1'b0);
    wait_drain();
    // Enable high on beat 0 only: whole block normalised.
    fill_mix(256, 512, -512); ex_exp = 13;
    send_block(4'b0001, 1'b0);
    wait_drain();
    // Enable low on beat 0, high afterwards: whole block truncated.
    fill_mix(256, 0, -1); ex_exp = 0;
    send_block(4'b1110, 1'b0);
    wait_drain();

    // Reset after beat 2 of a block, then a fresh block with normal latency.
    fill_mix(256, 512, -512);
    drive_beat(0, 1'b1);
    drive_beat(1, 1'b1);
    drive_beat(2, 1'b1);
    quiet = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    fill_const(1000, -1000, 1000, -1000); ex_exp = 12;
    send_block('1, 1'b0);
    quiet = 1'b0;
    wait_drain();

    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_done; i++) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
